// File: rtl/operand_pkg.sv
// Shared types and default constants for the operand loader.
package operand_pkg;

    localparam int unsigned N_DEFAULT         = 4;
    localparam int unsigned DB_CYCLES_DEFAULT = 500000;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10
    } state_t;

endpackage

// File: rtl/operand_loader_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse issued the cycle after the debounced level rises.
import operand_pkg::*;

module debounce #(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW   = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          press_q, press_d;

    // Any sample matching the current level restarts the stability count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = level_q & ~level_prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/operand_loader.sv
// Two-operand capture FSM driven by debounced enter/clear push-buttons.
import operand_pkg::*;

module operand_loader #(
    parameter int unsigned N         = N_DEFAULT,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] switches,
    input  logic         enter_btn,
    input  logic         clear_btn,
    output logic [N-1:0] firstNum,
    output logic [N-1:0] secNum,
    output logic         operands_valid,
    output logic [1:0]   state_leds
);

    logic         enter_p, clear_p;
    state_t       state_q;
    logic [N-1:0] first_q, sec_q;
    logic         valid_q;

    debounce #(.DB_CYCLES(DB_CYCLES)) u_enter_db (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (enter_btn),
        .press_o (enter_p)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_clear_db (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (clear_btn),
        .press_o (clear_p)
    );

    // Clear has priority over enter; the illegal encoding falls back to WAIT_A.
    always_ff @(posedge clk) begin
        if (rst || clear_p) begin
            state_q <= WAIT_A;
            first_q <= '0;
            sec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (enter_p) begin
                    first_q <= switches;
                    state_q <= WAIT_B;
                end
                WAIT_B: if (enter_p) begin
                    sec_q   <= switches;
                    state_q <= READY;
                    valid_q <= 1'b1;
                end
                READY: if (enter_p) begin
                    first_q <= switches;
                    state_q <= WAIT_B;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= WAIT_A;
                    first_q <= '0;
                    sec_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign firstNum       = first_q;
    assign secNum         = sec_q;
    assign operands_valid = valid_q;
    assign state_leds     = state_q;

endmodule
